// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over imem req/ack and hands code/pc to decode.
// Optional misaligned-redirect trap is enabled by defining MISALIGN_TRAP_EN.
package fetch_pkg;
    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;
    typedef logic [2:0]  sel_pc_t;

    localparam sel_pc_t SEL_PC_ADD4  = 3'd0;
    localparam sel_pc_t SEL_PC_JAL   = 3'd1;
    localparam sel_pc_t SEL_PC_JALR  = 3'd2;
    localparam sel_pc_t SEL_PC_MTVEC = 3'd3;
    localparam sel_pc_t SEL_PC_MEPC  = 3'd4;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter data_t NOP_CODE = 32'h0000_0013
) (
    input  logic    clk,
    input  logic    rst,
    output logic    imem_req,
    output addr_t   imem_addr,
    input  logic    imem_ack,
    input  data_t   imem_rdata,
    output data_t   code,
    output addr_t   pc,
    output logic    inst_valid,
    input  logic    inst_ready,
    input  sel_pc_t pc_sel,
    input  data_t   imm,
    input  data_t   rs1_data,
    input  addr_t   mtvec,
    input  addr_t   mepc,
    output logic    misalign_exc
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t state_reg, state_next;
    logic   req_reg, req_next;
    addr_t  fetch_pc_reg, fetch_pc_next;
    data_t  code_reg, code_next;
    addr_t  pc_reg, pc_next;
    logic   valid_reg, valid_next;
    logic   exc_reg, exc_next;

    addr_t  target;
    addr_t  redirect;
    logic   misalign;

    always_comb begin
        target = pc_reg + 32'd4;
        case (pc_sel)
            SEL_PC_JAL:   target = pc_reg + imm;
            SEL_PC_JALR:  target = (rs1_data + imm) & ~32'h1;
            SEL_PC_MTVEC: target = mtvec;
            SEL_PC_MEPC:  target = mepc;
            default:      target = pc_reg + 32'd4;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic is_jump;
    assign is_jump  = (pc_sel == SEL_PC_JAL) || (pc_sel == SEL_PC_JALR);
    // Only computed jumps can land misaligned; CSR and sequential targets pass through as-is.
    assign misalign = is_jump && (target[1:0] != 2'b00);
    assign redirect = misalign ? mtvec : target;
`else
    assign misalign = 1'b0;
    assign redirect = {target[31:2], 2'b00};
`endif

    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        fetch_pc_next = fetch_pc_reg;
        code_next     = code_reg;
        pc_next       = pc_reg;
        valid_next    = valid_reg;
        exc_next      = 1'b0;
        case (state_reg)
            FETCH: begin
                req_next = 1'b1;
                // req_reg gates ack so a stray ack right after reset is discarded.
                if (req_reg && imem_ack) begin
                    code_next  = imem_rdata;
                    pc_next    = fetch_pc_reg;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                req_next = 1'b0;
                if (inst_ready) begin
                    fetch_pc_next = redirect;
                    valid_next    = 1'b0;
                    code_next     = NOP_CODE;
                    req_next      = 1'b1;
                    exc_next      = misalign;
                    state_next    = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH;
            req_reg      <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            code_reg     <= NOP_CODE;
            pc_reg       <= RESET_PC;
            valid_reg    <= 1'b0;
            exc_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            fetch_pc_reg <= fetch_pc_next;
            code_reg     <= code_next;
            pc_reg       <= pc_next;
            valid_reg    <= valid_next;
            exc_reg      <= exc_next;
        end
    end

    assign imem_req     = req_reg;
    assign imem_addr    = fetch_pc_reg;
    assign code         = code_reg;
    assign pc           = pc_reg;
    assign inst_valid   = valid_reg;
    assign misalign_exc = exc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected requests/instructions, a negedge monitor checks them.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] T6_ADDR = 32'h0000_0200;
    localparam logic        T6_EXC  = 1'b1;
`else
    localparam logic [31:0] T6_ADDR = 32'h0000_0004;
    localparam logic        T6_EXC  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] code;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    sel_pc_t     pc_sel = SEL_PC_ADD4;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] mtvec = 32'h0;
    logic [31:0] mepc = 32'h0;
    logic        misalign_exc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_CODE(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .code(code), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc_sel(pc_sel), .imm(imm), .rs1_data(rs1_data), .mtvec(mtvec), .mepc(mepc),
        .misalign_exc(misalign_exc)
    );

    typedef struct { logic [31:0] addr; logic exc; } req_exp_t;
    typedef struct { logic [31:0] code; logic [31:0] pc; } inst_exp_t;

    req_exp_t  req_q[$];
    inst_exp_t inst_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor
    logic        req_seen = 1'b0, valid_seen = 1'b0;
    logic [31:0] held_addr, held_code, held_pc;
    req_exp_t    re;
    inst_exp_t   ie;

    always @(negedge clk) begin
        if (rst) begin
            req_seen   = 1'b0;
            valid_seen = 1'b0;
        end else begin
            if (imem_req && !req_seen) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h required no request", imem_addr);
                end else begin
                    re = req_q.pop_front();
                    chk("req_addr", imem_addr, re.addr);
                    chk("misalign_exc", 32'(misalign_exc), 32'(re.exc));
                end
                held_addr = imem_addr;
            end else begin
                if (imem_req) chk("addr_stable", imem_addr, held_addr);
                chk("exc_idle", 32'(misalign_exc), 32'h0);
            end
            req_seen = imem_req;

            if (inst_valid && !valid_seen) begin
                if (inst_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got code %h pc %h required none", code, pc);
                end else begin
                    ie = inst_q.pop_front();
                    chk("code", code, ie.code);
                    chk("pc", pc, ie.pc);
                end
                held_code = code;
                held_pc   = pc;
            end else if (inst_valid) begin
                chk("code_stable", code, held_code);
                chk("pc_stable", pc, held_pc);
            end else begin
                chk("nop_code", code, NOP);
            end
            valid_seen = inst_valid;
        end
    end

    task automatic check_reset_state();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_code", code, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_exc", 32'(misalign_exc), 32'h0);
    endtask

    task automatic wait_req(output logic ok);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = imem_req;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL req_timeout: got imem_req 0 required 1 within 50 cycles");
        end
    endtask

    // One fetch/accept: ack after ack_wait stall cycles, hold for 'hold' cycles, then accept with sel.
    task automatic xact(input logic [31:0] rdata, input logic [31:0] exp_pc, input int ack_wait,
                        input int hold, input sel_pc_t sel, input logic [31:0] imm_v,
                        input logic [31:0] rs1_v, input logic [31:0] mtvec_v, input logic [31:0] mepc_v,
                        input logic [31:0] exp_next, input logic exp_exc);
        logic ok;
        wait_req(ok);
        if (!ok) return;
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        pc_sel     = SEL_PC_JAL;
        repeat (ack_wait) begin @(posedge clk); #1; end
        inst_ready = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        inst_q.push_back('{code: rdata, pc: exp_pc});
        @(posedge clk); #1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (hold) begin @(posedge clk); #1; end
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        pc_sel     = sel;
        imm        = imm_v;
        rs1_data   = rs1_v;
        mtvec      = mtvec_v;
        mepc       = mepc_v;
        req_q.push_back('{addr: exp_next, exc: exp_exc});
        @(posedge clk); #1;
        inst_ready = 1'b0;
        pc_sel     = SEL_PC_JALR;
        imm        = 32'h1357_9BDF;
        $display("xact pc=%h code=%h sel=%0d expected_next=%h exc=%0b", exp_pc, rdata, sel, exp_next, exp_exc);
    endtask

    initial begin
        logic ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        req_q.push_back('{addr: 32'h0, exc: 1'b0});

        xact(32'h0050_0093, 32'h0000_0000, 0, 5, SEL_PC_ADD4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0004, 1'b0);
        xact(32'h0000_0113, 32'h0000_0004, 3, 0, SEL_PC_MEPC, 32'h0, 32'h0, 32'h0, 32'h0000_0100, 32'h0000_0100, 1'b0);
        xact(32'h1111_1111, 32'h0000_0100, 1, 1, SEL_PC_JAL, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0, 32'h0000_00F0, 1'b0);
        xact(32'h2222_2222, 32'h0000_00F0, 0, 2, SEL_PC_JALR, 32'h0000_0002, 32'h0000_0203, 32'h0, 32'h0, 32'h0000_0204, 1'b0);
        xact(32'h3333_3333, 32'h0000_0204, 2, 0, SEL_PC_MTVEC, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
        xact(32'h4444_4444, 32'h8000_0000, 0, 0, SEL_PC_MEPC, 32'h0, 32'h0, 32'h0, 32'h0000_0044, 32'h0000_0044, 1'b0);
        xact(32'h5555_5555, 32'h0000_0044, 0, 1, sel_pc_t'(3'd7), 32'h0000_0100, 32'h0, 32'h0, 32'h0, 32'h0000_0048, 1'b0);
        xact(32'h6666_6666, 32'h0000_0048, 0, 0, SEL_PC_MEPC, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        xact(32'h7777_7777, 32'hFFFF_FFFC, 1, 0, SEL_PC_ADD4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        xact(32'h8888_8888, 32'h0000_0000, 0, 0, SEL_PC_JAL, 32'h0000_0006, 32'h0, 32'h0000_0200, 32'h0, T6_ADDR, T6_EXC);
        xact(32'h9999_9999, T6_ADDR, 0, 0, SEL_PC_ADD4, 32'h0, 32'h0, 32'h0, 32'h0, T6_ADDR + 32'd4, 1'b0);

        // Reset while a request is outstanding, with ack landing in the reset cycle.
        wait_req(ok);
        @(negedge clk); #1;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
        @(posedge clk); #1;
        check_reset_state();
        rst = 1'b0;
        req_q.push_back('{addr: 32'h0, exc: 1'b0});
        xact(32'h00A0_0193, 32'h0000_0000, 2, 0, SEL_PC_ADD4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0004, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_empty", 32'(req_q.size()), 32'h0);
        chk("inst_q_empty", 32'(inst_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
